// File: rtl/ttt_turn_arbiter.sv
// ttt_turn_arbiter: grants the tic-tac-toe core to one keypad per turn, turns key edges into move pulses,
// times each turn and latches the game result.
module ttt_turn_arbiter #(
    parameter int TURN_CYCLES = 50_000_000,
    parameter int LOCK_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] px_key,
    input  logic [5:0] po_key,
    input  logic       place_ack,
    input  logic       win_flag,
    input  logic       new_game,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       enter,
    output logic       space,
    output logic       turn_o,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       forfeit
);
    typedef enum logic [1:0] {LOCK, ACTIVE, OVER} state_t;

    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    if (TURN_CYCLES < 2 || LOCK_CYCLES < 1 ||
        64'(TURN_CYCLES) > (64'(1) << CNT_W)) begin : g_param_check
        $error("ttt_turn_arbiter: TURN_CYCLES must be >= 2 and fit CNT_W, LOCK_CYCLES >= 1");
    end

    state_t           state_q, state_d;
    logic             turn_q, turn_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [5:0]       hist_q, hist_d;
    logic [5:0]       pulse_q, pulse_d;
    logic [1:0]       winner_q, winner_d;
    logic             forfeit_q, forfeit_d;
    logic [5:0]       own_key, edges, pick;

    assign own_key = turn_q ? po_key : px_key;
    assign edges   = own_key & ~hist_q;
    // bit 5 (space) has the highest priority, bit 0 (up) the lowest
    assign pick = edges[5] ? 6'b100000 :
                  edges[4] ? 6'b010000 :
                  edges[3] ? 6'b001000 :
                  edges[2] ? 6'b000100 :
                  edges[1] ? 6'b000010 :
                  edges[0] ? 6'b000001 : 6'b000000;

    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        lock_cnt_d = lock_cnt_q;
        timer_d    = timer_q;
        hist_d     = hist_q;
        pulse_d    = 6'b0;
        winner_d   = winner_q;
        forfeit_d  = forfeit_q;
        case (state_q)
            LOCK: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                timer_d    = '0;
                hist_d     = own_key;
                if (win_flag) begin
                    state_d   = OVER;
                    winner_d  = turn_q ? 2'b10 : 2'b01;
                    forfeit_d = 1'b0;
                end else if (lock_cnt_q >= LOCK_LAST && own_key == 6'b0) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                timer_d = timer_q + CNT_W'(1);
                hist_d  = own_key;
                if (win_flag) begin
                    state_d   = OVER;
                    winner_d  = turn_q ? 2'b10 : 2'b01;
                    forfeit_d = 1'b0;
                end else if (place_ack) begin
                    state_d    = LOCK;
                    turn_d     = ~turn_q;
                    timer_d    = '0;
                    lock_cnt_d = '0;
                    hist_d     = 6'b111111;
                end else if (timer_q == TURN_LAST) begin
                    state_d   = OVER;
                    winner_d  = turn_q ? 2'b01 : 2'b10;
                    forfeit_d = 1'b1;
                end else begin
                    pulse_d = pick;
                end
            end
            OVER: begin
                hist_d = 6'b111111;
                if (new_game) begin
                    state_d    = LOCK;
                    turn_d     = 1'b0;
                    winner_d   = 2'b00;
                    forfeit_d  = 1'b0;
                    lock_cnt_d = '0;
                    timer_d    = '0;
                end
            end
            default: state_d = LOCK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOCK;
            turn_q     <= 1'b0;
            lock_cnt_q <= '0;
            timer_q    <= '0;
            hist_q     <= 6'b111111;
            pulse_q    <= 6'b0;
            winner_q   <= 2'b00;
            forfeit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            lock_cnt_q <= lock_cnt_d;
            timer_q    <= timer_d;
            hist_q     <= hist_d;
            pulse_q    <= pulse_d;
            winner_q   <= winner_d;
            forfeit_q  <= forfeit_d;
        end
    end

    assign {space, enter, right, left, down, up} = pulse_q;
    assign turn_o    = turn_q;
    assign game_over = state_q == OVER;
    assign winner    = winner_q;
    assign forfeit   = forfeit_q;
endmodule
